// File: rtl/shift_serializer_if.sv
// Handshake and serial-output bundle for shift_serializer.
// The master side offers parallel words; the slave side serialises them.
interface shift_serializer_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0] TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;
  logic             SER_DATA;
  logic             SER_LOAD;
  logic             WORD_DONE;
  logic             BUSY;

  modport master (
    output TX_DATA,
    output TX_VALID,
    input  TX_READY,
    input  SER_DATA,
    input  SER_LOAD,
    input  WORD_DONE,
    input  BUSY
  );

  modport slave (
    input  TX_DATA,
    input  TX_VALID,
    output TX_READY,
    output SER_DATA,
    output SER_LOAD,
    output WORD_DONE,
    output BUSY
  );

endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial converter feeding a downstream serial-in shift register.
// Words are sent MSB first with SER_LOAD as the downstream shift enable. A
// single holding register lets the source hand over the next word while the
// current one is shifting, so words with GAP == 0 run back-to-back with no
// bubble. GAP > 0 inserts that many idle cycles after every word.
module shift_serializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input logic               CLK,
  input logic               RESET_B,
  shift_serializer_if.slave bus_io
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  // GAP is at most 15, so a 4-bit gap counter always suffices.
  localparam logic [3:0]      GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGapWait
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             word_done_q, word_done_d;

  logic tx_ready;
  logic accept;
  logic last_bit;
  logic gap_end;

  // Ready depends only on the hold flag and reset, never on TX_VALID.
  assign tx_ready = RESET_B && !hold_full_q;
  assign accept   = bus_io.TX_VALID && tx_ready;
  assign last_bit = (state_q == StShift) && (cnt_q == CntLast);
  assign gap_end  = (state_q == StGapWait) && (gap_q == GapLast);

  // Next-state logic for the FSM, shift/hold datapath and counters.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    // WORD_DONE follows the last-bit cycle by exactly one cycle.
    word_done_d = last_bit;

    case (state_q)
      StIdle: begin
        // Hold is always empty here, so an accepted word goes straight out.
        if (accept) begin
          shift_d = bus_io.TX_DATA;
          cnt_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CntW'(1);
        if (!last_bit) begin
          if (accept) begin
            hold_d      = bus_io.TX_DATA;
            hold_full_d = 1'b1;
          end
        end else if (GAP > 0) begin
          state_d = StGapWait;
          gap_d   = '0;
          cnt_d   = '0;
          if (accept) begin
            hold_d      = bus_io.TX_DATA;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Ready is low while hold is full, so no acceptance competes here.
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          shift_d = bus_io.TX_DATA;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end

      StGapWait: begin
        gap_d = gap_q + 4'd1;
        if (!gap_end) begin
          if (accept) begin
            hold_d      = bus_io.TX_DATA;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = StShift;
        end else if (accept) begin
          shift_d = bus_io.TX_DATA;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset drops any in-flight or held word at once.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      word_done_q <= word_done_d;
    end
  end

  // Outputs decode registers only, so they all read 0 while reset is held.
  assign bus_io.TX_READY  = tx_ready;
  assign bus_io.SER_LOAD  = (state_q == StShift);
  assign bus_io.SER_DATA  = (state_q == StShift) && shift_q[WIDTH-1];
  assign bus_io.WORD_DONE = word_done_q;
  assign bus_io.BUSY      = (state_q != StIdle) || hold_full_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer (WIDTH=4), GAP=0 and GAP=2 instances.
module tb_shift_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n;
  logic rst2_n;

  shift_serializer_if #(.WIDTH(4)) if0 ();
  shift_serializer_if #(.WIDTH(4)) if2 ();

  shift_serializer #(.WIDTH(4), .GAP(0)) dut0 (
    .CLK    (clk),
    .RESET_B(rst0_n),
    .bus_io (if0)
  );

  shift_serializer #(.WIDTH(4), .GAP(2)) dut2 (
    .CLK    (clk),
    .RESET_B(rst2_n),
    .bus_io (if2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues of expected serial bits, pushed at acceptance.
  logic exp_q0[$];
  logic exp_q2[$];
  logic hist0[$];
  logic hist2[$];
  int   bitpos0 = 0, bitpos2 = 0;
  logic wd_pend0 = 1'b0, wd_pend2 = 1'b0;
  int   wd_cnt0 = 0, wd_cnt2 = 0;
  logic [3:0] dsr0 = 4'h0, dsr2 = 4'h0;

  // Downstream serial-in registers, MSB first into bit 0.
  always @(posedge clk) begin
    if (if0.SER_LOAD === 1'b1) dsr0 <= {dsr0[2:0], if0.SER_DATA};
    if (if2.SER_LOAD === 1'b1) dsr2 <= {dsr2[2:0], if2.SER_DATA};
  end

  // Monitor for the GAP=0 instance.
  always @(negedge clk) begin
    if (!rst0_n) begin
      check("rst_outputs0", 32'({if0.SER_LOAD, if0.SER_DATA, if0.WORD_DONE, if0.BUSY,
                                 if0.TX_READY}), 32'd0);
      bitpos0  = 0;
      wd_pend0 = 1'b0;
    end else begin
      check("word_done0", 32'(if0.WORD_DONE), 32'(wd_pend0));
      if (if0.WORD_DONE === 1'b1) wd_cnt0++;
      wd_pend0 = 1'b0;
      hist0.push_back(if0.SER_LOAD);
      if (if0.SER_LOAD === 1'b1) begin
        if (exp_q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ser_pending0: SER_LOAD=1 with no word outstanding (t=%0t)", $time);
        end else begin
          check("ser_data0", 32'(if0.SER_DATA), 32'(exp_q0.pop_front()));
          bitpos0++;
          if (bitpos0 == 4) begin
            bitpos0  = 0;
            wd_pend0 = 1'b1;
          end
        end
      end else begin
        check("ser_idle_zero0", 32'(if0.SER_DATA), 32'd0);
      end
    end
  end

  // Monitor for the GAP=2 instance.
  always @(negedge clk) begin
    if (!rst2_n) begin
      check("rst_outputs2", 32'({if2.SER_LOAD, if2.SER_DATA, if2.WORD_DONE, if2.BUSY,
                                 if2.TX_READY}), 32'd0);
      bitpos2  = 0;
      wd_pend2 = 1'b0;
    end else begin
      check("word_done2", 32'(if2.WORD_DONE), 32'(wd_pend2));
      if (if2.WORD_DONE === 1'b1) wd_cnt2++;
      wd_pend2 = 1'b0;
      hist2.push_back(if2.SER_LOAD);
      if (if2.SER_LOAD === 1'b1) begin
        if (exp_q2.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ser_pending2: SER_LOAD=1 with no word outstanding (t=%0t)", $time);
        end else begin
          check("ser_data2", 32'(if2.SER_DATA), 32'(exp_q2.pop_front()));
          bitpos2++;
          if (bitpos2 == 4) begin
            bitpos2  = 0;
            wd_pend2 = 1'b1;
          end
        end
      end else begin
        check("ser_idle_zero2", 32'(if2.SER_DATA), 32'd0);
      end
    end
  end

  // Offer one word; returns #1 after the accepting edge. keep leaves VALID high.
  task automatic send(input int d, input logic [3:0] data, input bit keep);
    bit   done;
    logic rdy;
    done = 1'b0;
    if (d == 0) begin
      if0.TX_VALID = 1'b1;
      if0.TX_DATA  = data;
    end else begin
      if2.TX_VALID = 1'b1;
      if2.TX_DATA  = data;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      rdy = (d == 0) ? if0.TX_READY : if2.TX_READY;
      @(posedge clk);
      if (rdy === 1'b1) begin
        done = 1'b1;
        for (int b = 3; b >= 0; b--) begin
          if (d == 0) exp_q0.push_back(data[b]);
          else        exp_q2.push_back(data[b]);
        end
      end
    end
    #1;
    if (!keep) begin
      if (d == 0) if0.TX_VALID = 1'b0;
      else        if2.TX_VALID = 1'b0;
    end
    check("accepted", 32'(done), 32'd1);
  endtask

  // Wait until all expected bits are out and the block is idle; ends at posedge+1.
  task automatic drain(input int d);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      if (d == 0) idle = (exp_q0.size() == 0) && (if0.BUSY === 1'b0);
      else        idle = (exp_q2.size() == 0) && (if2.BUSY === 1'b0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_idle", 32'(idle), 32'd1);
  endtask

  // Count SER_LOAD-high cycles and the span from first to last high cycle.
  task automatic load_span(input int d, output int ones, output int span);
    int first, last;
    first = -1;
    last  = -1;
    ones  = 0;
    if (d == 0) begin
      foreach (hist0[i]) if (hist0[i] === 1'b1) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    end else begin
      foreach (hist2[i]) if (hist2[i] === 1'b1) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    end
    span = (first < 0) ? 0 : last - first + 1;
  endtask

  typedef struct {
    logic [3:0] data;
    logic [3:0] exp_dsr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ones, span, wb;

    vecs[0] = '{data: 4'b1011, exp_dsr: 4'b1011};
    vecs[1] = '{data: 4'b0000, exp_dsr: 4'b0000};
    vecs[2] = '{data: 4'b1111, exp_dsr: 4'b1111};
    vecs[3] = '{data: 4'b1000, exp_dsr: 4'b1000};
    vecs[4] = '{data: 4'b0001, exp_dsr: 4'b0001};
    vecs[5] = '{data: 4'b0110, exp_dsr: 4'b0110};

    rst0_n       = 1'b0;
    rst2_n       = 1'b0;
    if0.TX_VALID = 1'b0;
    if0.TX_DATA  = 4'h0;
    if2.TX_VALID = 1'b0;
    if2.TX_DATA  = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    rst2_n = 1'b1;
    #1;
    check("post_rst0", 32'({if0.TX_READY, if0.BUSY, if0.SER_LOAD, if0.WORD_DONE}), 32'b1000);
    check("post_rst2", 32'({if2.TX_READY, if2.BUSY, if2.SER_LOAD, if2.WORD_DONE}), 32'b1000);
    @(posedge clk);
    #1;

    // Single isolated words, GAP=0.
    for (int v = 0; v < 6; v++) begin
      hist0.delete();
      wb = wd_cnt0;
      send(0, vecs[v].data, 1'b0);
      drain(0);
      load_span(0, ones, span);
      check("tbl_load_ones", 32'(ones), 32'd4);
      check("tbl_load_span", 32'(span), 32'd4);
      check("tbl_dsr", 32'(dsr0), 32'(vecs[v].exp_dsr));
      check("tbl_word_done", 32'(wd_cnt0 - wb), 32'd1);
    end

    // Two words offered back to back: second waits in the hold register.
    hist0.delete();
    wb = wd_cnt0;
    send(0, 4'hA, 1'b1);
    send(0, 4'h5, 1'b0);
    @(negedge clk);
    check("hold_full_ready", 32'({if0.TX_READY, if0.BUSY}), 32'b01);
    drain(0);
    load_span(0, ones, span);
    check("b2b_ones", 32'(ones), 32'd8);
    check("b2b_span", 32'(span), 32'd8);
    check("b2b_dsr", 32'(dsr0), 32'h5);
    check("b2b_word_done", 32'(wd_cnt0 - wb), 32'd2);

    // Second word first offered in the last-bit cycle, hold empty.
    hist0.delete();
    send(0, 4'h9, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(0, 4'h6, 1'b0);
    drain(0);
    load_span(0, ones, span);
    check("late_ones", 32'(ones), 32'd8);
    check("late_span", 32'(span), 32'd8);
    check("late_dsr", 32'(dsr0), 32'h6);

    // Reset two bits into 4'hC, then send 4'h3.
    wb = wd_cnt0;
    send(0, 4'hC, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b0;
    exp_q0.delete();
    #1;
    check("rst_mid_outputs",
          32'({if0.SER_LOAD, if0.BUSY, if0.TX_READY, if0.WORD_DONE, if0.SER_DATA}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(if0.TX_READY), 32'd1);
    hist0.delete();
    send(0, 4'h3, 1'b0);
    drain(0);
    load_span(0, ones, span);
    check("after_rst_span", 32'(span), 32'd4);
    check("after_rst_dsr", 32'(dsr0), 32'h3);
    check("after_rst_word_done", 32'(wd_cnt0 - wb), 32'd1);

    // Long idle stretch.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle20", 32'({if0.SER_LOAD, if0.BUSY, if0.WORD_DONE, if0.TX_READY}), 32'b0001);
    end
    @(posedge clk);
    #1;

    // GAP=2: second word held during the first.
    hist2.delete();
    wb = wd_cnt2;
    send(2, 4'hA, 1'b1);
    send(2, 4'h6, 1'b0);
    drain(2);
    load_span(2, ones, span);
    check("gap_hold_ones", 32'(ones), 32'd8);
    check("gap_hold_span", 32'(span), 32'd10);
    check("gap_hold_dsr", 32'(dsr2), 32'h6);
    check("gap_hold_word_done", 32'(wd_cnt2 - wb), 32'd2);

    // GAP=2: second word first offered in the final gap cycle.
    hist2.delete();
    wb = wd_cnt2;
    send(2, 4'h3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send(2, 4'hC, 1'b0);
    drain(2);
    load_span(2, ones, span);
    check("gap_end_ones", 32'(ones), 32'd8);
    check("gap_end_span", 32'(span), 32'd10);
    check("gap_end_dsr", 32'(dsr2), 32'hC);
    check("gap_end_word_done", 32'(wd_cnt2 - wb), 32'd2);

    check("sb_empty0", 32'(exp_q0.size()), 32'd0);
    check("sb_empty2", 32'(exp_q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 Parameter WIDTH, default 4, word width in bits; legal range 2..16.
REQ-002 Parameter GAP, default 0, idle cycles inserted after each word; legal range 0..15.
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 RESET_B  input  1  reset, asynchronous, active-low.
REQ-005 TX_DATA  input  WIDTH  parallel word to transmit; sampled only on acceptance.
REQ-006 TX_VALID  input  1  source offers TX_DATA.
REQ-007 TX_READY  output  1  block can accept a word this cycle.
REQ-008 SER_DATA  output  1  serial bit stream, MSB first, for a downstream serial-in shift register's bit 0.
REQ-009 SER_LOAD  output  1  shift-enable strobe for the downstream register; high for exactly the bit cycles.
REQ-010 WORD_DONE  output  1  one-cycle pulse after a word's last bit.
REQ-011 BUSY  output  1  a word is in flight, in a GAP period, or held.

Function
REQ-012 Acceptance SHALL occur at a posedge where TX_VALID && TX_READY are both high.
REQ-013 Storage SHALL be one WIDTH-bit shift register, one WIDTH-bit holding register with a full flag, and a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 TX_READY SHALL equal RESET_B && !hold_full, combinational from registers only, never from TX_VALID.
REQ-015 The state machine SHALL have exactly three states: IDLE, SHIFT, GAP_WAIT.
REQ-016 IDLE with acceptance SHALL load TX_DATA directly into the shift register, set the bit counter to 0, and go to SHIFT.
REQ-017 In SHIFT, SER_LOAD SHALL be 1 and SER_DATA SHALL equal shift-register bit WIDTH-1; the register shifts left one bit per cycle.
REQ-018 For a word accepted at edge k, bit WIDTH-1-i SHALL appear on SER_DATA in cycle k+1+i, for i = 0..WIDTH-1.
REQ-019 This gives first-bit latency 1 cycle and SER_LOAD high for exactly WIDTH consecutive cycles.
REQ-020 Acceptance during SHIFT or GAP_WAIT SHALL write the holding register and set hold_full.
REQ-021 On the last bit cycle (counter == WIDTH-1) with GAP > 0, the next state SHALL be GAP_WAIT for exactly GAP cycles with SER_LOAD 0.
REQ-022 On the last bit cycle with GAP == 0: if hold_full, move the hold word to the shift register, clear hold_full, and stay in SHIFT.
REQ-023 Same case, else if accepting this cycle, load TX_DATA directly into the shift register and stay in SHIFT.
REQ-024 Same case, otherwise go to IDLE.
REQ-025 Under REQ-022/023, SER_LOAD SHALL remain continuously high across word boundaries (back-to-back).
REQ-026 At the end of GAP_WAIT: hold_full leads to SHIFT with the hold word; acceptance in that cycle with hold empty leads to SHIFT with TX_DATA; otherwise IDLE.
REQ-027 WORD_DONE SHALL pulse high for one cycle in the cycle after each last-bit cycle.
REQ-028 WORD_DONE SHALL coincide with the next word's first bit when words run back-to-back.
REQ-029 SER_DATA SHALL be 0 whenever SER_LOAD is 0.
REQ-030 BUSY SHALL equal (state != IDLE) || hold_full.
REQ-031 A word SHALL never be dropped, duplicated or reordered; at most two words (shift plus hold) are in flight.
REQ-032 The source SHALL keep TX_VALID and TX_DATA stable until acceptance; TX_DATA SHALL be free of X while TX_VALID is high.

Reset
REQ-033 RESET_B low SHALL immediately clear state to IDLE, the counter, hold_full and the shift register.
REQ-034 While RESET_B is low, outputs SHALL be SER_LOAD=0, SER_DATA=0, WORD_DONE=0, BUSY=0, TX_READY=0.
REQ-035 Reset mid-word SHALL discard the in-flight and held words with no WORD_DONE.
REQ-036 The first posedge after RESET_B rises SHALL be able to accept a word (TX_READY=1).
REQ-037 After reset release, all outputs SHALL be X-free.

Verification (WIDTH=4)
REQ-038 GAP=0, TX_DATA=4'b1011 valid one cycle -> SER_LOAD high 4 cycles, SER_DATA 1,0,1,1; WORD_DONE pulse next cycle; a downstream 4-bit serial-in register shows 4'b1011.
REQ-039 GAP=0, words 4'hA then 4'h5 offered continuously -> SER_LOAD high 8 consecutive cycles, bits 1,0,1,0,0,1,0,1; TX_READY low while the hold register is full.
REQ-040 GAP=2, two words -> exactly 2 cycles of SER_LOAD=0/SER_DATA=0 between them; WORD_DONE pulses twice.
REQ-041 GAP=0, hold empty, TX_VALID first asserted in the last-bit cycle -> the new word's MSB is driven the next cycle with no SER_LOAD gap.
REQ-042 RESET_B pulsed low after 2 bits of 4'hC -> SER_LOAD and BUSY drop immediately, no WORD_DONE; 4'h3 sent after release -> full 0,0,1,1 sequence.
REQ-043 Idle with TX_VALID low for 20 cycles -> SER_LOAD, BUSY and WORD_DONE stay 0 and TX_READY stays 1.
